memoria_principal_part: RTL
===========================

Name: memoria_principal_part

Overview:
- Parametrised main-memory block for the CPU datapath: single-port word RAM with partitioned addressing, a registered read path and a hardware clear engine.
- The CPU selects a partition base through hd_set (base = hd_set * PART_WORDS). All loads and stores are relative to that base, so each resident program sees its own address window.
- Sits between the control unit (controle_memoria) and the register file (registrador_memoria).

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, logical address width
DEPTH, 64, number of physical words
PART_WORDS, 8, words per partition (base step)
HD_W, 3, width of hd_set partition index

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
controle_memoria  in  2  command: 00 read, 01 write, 10 set partition, 11 clear memory
hd_set  in  HD_W  partition index, sampled on command 10
endereco_memoria  in  ADDR_W  logical address
store  in  DATA_W  write data
registrador_memoria  out  DATA_W  registered read data
dado_valido  out  1  one-cycle pulse: registrador_memoria updated by a read
ocupado  out  1  high while the clear engine runs; commands ignored
erro_memoria  out  1  one-cycle pulse on illegal access or illegal partition
erro_paridade  out  1  parity error pulse (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): registrador_memoria=0, dado_valido=0, ocupado=0, erro_memoria=0, erro_paridade=0, base=0, state=OCIOSO, clear counter=0. RAM contents are not reset.
- Physical address: phys = base + endereco_memoria.
  - Computed at width max(ADDR_W, clog2(DEPTH)) + 1, no wrap-around.
  - Access is illegal if phys >= DEPTH.
- State OCIOSO, commands sampled each posedge:
  - 00 read, legal: next cycle registrador_memoria = mem[phys] and dado_valido = 1. Latency is 1 clock.
  - 00 read, illegal: registrador_memoria = 0, dado_valido = 1, erro_memoria = 1.
  - 01 write, legal: mem[phys] = store at this edge. registrador_memoria unchanged; dado_valido = 0.
  - 01 write, illegal: memory untouched; erro_memoria = 1.
  - 10 set partition: if hd_set * PART_WORDS < DEPTH, base = hd_set * PART_WORDS, effective from the next command. Otherwise base is kept and erro_memoria = 1.
  - 11 clear: state goes to LIMPANDO and ocupado = 1 next cycle. Counter starts at 0.
- State LIMPANDO:
  - Each cycle writes mem[counter] = 0 and increments counter. The clear ignores base and covers the whole of physical memory.
  - All commands are ignored; no error is raised; dado_valido = 0.
  - On the cycle counter = DEPTH-1 the state returns to OCIOSO. ocupado = 0 from the following cycle, so the clear occupies exactly DEPTH cycles of ocupado high.
- dado_valido and erro_memoria are single-cycle pulses and are 0 in any cycle without a triggering event. registrador_memoria holds its value between reads.
- Reset mid-clear: the engine aborts at that edge and ocupado = 0 next cycle. Words already cleared stay 0; remaining words keep their old contents.
- Back-to-back commands: a write followed immediately by a read of the same address returns the new data.

Optional Feature:
- Macro MEM_PARIDADE_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from store on write.
  - On a legal read, stored parity is checked; on mismatch erro_paridade pulses with dado_valido, and the data is still delivered.
  - Clear writes parity 0.
- Undefined: no parity storage; erro_paridade tied to 0.

Test Plan:
1. rst for 2 cycles -> all outputs 0. Write 0x1234 to addr 5, then read addr 5 -> next cycle registrador_memoria=0x1234, dado_valido=1, erro_memoria=0.
2. Command 10 with hd_set=3 (base 24); write 0xBEEF to addr 2; command 10 with hd_set=0; read addr 26 -> 0xBEEF.
3. hd_set=7 (base 56); write 0xAAAA to addr 8 (phys 64) -> erro_memoria pulses, no write. Read addr 8 -> data 0x0000 with erro_memoria=1. Read addr 7 -> mem[63].
4. Command 10 with DEPTH=64, PART_WORDS=16, hd_set=4 (base 64) -> erro_memoria=1, base unchanged (confirmed by read addr 0).
5. Fill word 5=0x1111 and word 40=0x2222; command 11 -> ocupado high exactly 64 cycles; a write issued meanwhile is ignored. Afterwards reads of 5 and 40 -> 0x0000.
6. Fill words 0..63 with 0xFFFF; command 11; assert rst at the 10th cycle of ocupado -> ocupado=0 next cycle. Words 0..8 read 0x0000, word 30 reads 0xFFFF. With MEM_PARIDADE_EN, no erro_paridade on any read.

Source files
------------

// File: rtl/memoria_principal_part_if.sv
// Bus between controle_memoria / registrador_memoria and the partitioned main memory.
interface memoria_principal_part_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int HD_W   = 3
);
   logic [1:0]        controle_memoria;
   logic [HD_W-1:0]   hd_set;
   logic [ADDR_W-1:0] endereco_memoria;
   logic [DATA_W-1:0] store;
   logic [DATA_W-1:0] registrador_memoria;
   logic              dado_valido;
   logic              ocupado;
   logic              erro_memoria;
   logic              erro_paridade;

   modport master (
      output controle_memoria, hd_set, endereco_memoria, store,
      input  registrador_memoria, dado_valido, ocupado, erro_memoria, erro_paridade
   );

   modport slave (
      input  controle_memoria, hd_set, endereco_memoria, store,
      output registrador_memoria, dado_valido, ocupado, erro_memoria, erro_paridade
   );
endinterface

// File: rtl/memoria_principal_part.sv
// Partitioned single-port word RAM with registered reads and a whole-memory clear engine.
// Optional per-word even parity is enabled by defining MEM_PARIDADE_EN.
module memoria_principal_part #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int DEPTH      = 64,
   parameter int PART_WORDS = 8,
   parameter int HD_W       = 3
) (
   input logic clk,
   input logic rst,
   memoria_principal_part_if.slave bus
);
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = ((ADDR_W > CW) ? ADDR_W : CW) + 1;

   typedef enum logic {Ocioso, Limpando} state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state_q;
   logic [CW-1:0]     counter_q;
   logic [PW-1:0]     base_q;
   logic [DATA_W-1:0] registrador_q;
   logic              dado_valido_q;
   logic              ocupado_q;
   logic              erro_q;

   logic [PW-1:0]     phys;
   logic [CW-1:0]     idx;
   logic              legal;
   logic [31:0]       base_cand;
   logic              base_ok;

   // Wide enough that base + address never wraps back into range.
   assign phys      = base_q + PW'(bus.endereco_memoria);
   assign legal     = phys < PW'(DEPTH);
   assign idx       = phys[CW-1:0];
   assign base_cand = 32'(bus.hd_set) * 32'(PART_WORDS);
   assign base_ok   = base_cand < 32'(DEPTH);

`ifdef MEM_PARIDADE_EN
   logic par_mem [DEPTH];
   logic paridade_q;
   assign bus.erro_paridade = paridade_q;
`else
   assign bus.erro_paridade = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= Ocioso;
         counter_q     <= '0;
         base_q        <= '0;
         registrador_q <= '0;
         dado_valido_q <= 1'b0;
         ocupado_q     <= 1'b0;
         erro_q        <= 1'b0;
`ifdef MEM_PARIDADE_EN
         paridade_q    <= 1'b0;
`endif
      end else begin
         dado_valido_q <= 1'b0;
         erro_q        <= 1'b0;
`ifdef MEM_PARIDADE_EN
         paridade_q    <= 1'b0;
`endif
         unique case (state_q)
            Ocioso: begin
               case (bus.controle_memoria)
                  2'b00: begin
                     dado_valido_q <= 1'b1;
                     if (legal) begin
                        registrador_q <= mem[idx];
`ifdef MEM_PARIDADE_EN
                        paridade_q    <= (^mem[idx]) != par_mem[idx];
`endif
                     end else begin
                        registrador_q <= '0;
                        erro_q        <= 1'b1;
                     end
                  end
                  2'b01: begin
                     if (legal) begin
                        mem[idx] <= bus.store;
`ifdef MEM_PARIDADE_EN
                        par_mem[idx] <= ^bus.store;
`endif
                     end else begin
                        erro_q <= 1'b1;
                     end
                  end
                  2'b10: begin
                     if (base_ok) base_q <= PW'(base_cand);
                     else         erro_q <= 1'b1;
                  end
                  default: begin
                     state_q   <= Limpando;
                     ocupado_q <= 1'b1;
                     counter_q <= '0;
                  end
               endcase
            end
            Limpando: begin
               // Clear sweeps physical memory regardless of the partition base.
               mem[counter_q] <= '0;
`ifdef MEM_PARIDADE_EN
               par_mem[counter_q] <= 1'b0;
`endif
               counter_q <= counter_q + CW'(1);
               if (counter_q == CW'(DEPTH - 1)) begin
                  state_q   <= Ocioso;
                  ocupado_q <= 1'b0;
               end
            end
            default: state_q <= Ocioso;
         endcase
      end
   end

   assign bus.registrador_memoria = registrador_q;
   assign bus.dado_valido         = dado_valido_q;
   assign bus.ocupado             = ocupado_q;
   assign bus.erro_memoria        = erro_q;
endmodule
